// File: rtl/t03_pixel_counter.sv
`default_nettype none
// ============================================================================
// Module   : t03_pixel_counter
// Purpose  : Pixel-rate divider driving free-running Hcnt/Vcnt plus line/frame
//            strobes. Optional frame counter enabled by T03_FRAME_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module t03_pixel_counter #(
    parameter int CLK_DIV = 2,
    parameter int H_TOTAL = 200,
    parameter int V_TOTAL = 632
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [10:0] Hcnt,
    output logic [10:0] Vcnt,
    output logic        pix_tick,
    output logic        line_start,
`ifdef T03_FRAME_COUNT_EN
    output logic        frame_start,
    output logic [7:0]  frame_cnt
`else
    output logic        frame_start
`endif
);

    localparam int               DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [10:0]      c_H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0]      c_V_LAST   = 11'(V_TOTAL - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic [10:0]      r_hcnt;
    logic [10:0]      r_vcnt;
    logic             r_line_start;
    logic             r_frame_start;

    logic             w_pix_tick;
    logic             w_h_wrap;
    logic             w_v_wrap;

    // >= rather than == so an out-of-range count recovers on the next tick
    assign w_pix_tick = en && (r_div_cnt == c_DIV_LAST);
    assign w_h_wrap   = (r_hcnt >= c_H_LAST);
    assign w_v_wrap   = (r_vcnt >= c_V_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt     <= '0;
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            if (en) begin
                if (r_div_cnt == c_DIV_LAST) begin
                    r_div_cnt <= '0;
                end else begin
                    r_div_cnt <= r_div_cnt + 1'b1;
                end
            end

            if (w_pix_tick) begin
                if (w_h_wrap) begin
                    r_hcnt <= '0;
                    r_vcnt <= w_v_wrap ? 11'd0 : (r_vcnt + 11'd1);
                end else begin
                    r_hcnt <= r_hcnt + 11'd1;
                end
            end

            r_line_start  <= w_pix_tick && w_h_wrap;
            r_frame_start <= w_pix_tick && w_h_wrap && w_v_wrap;
        end
    end

`ifdef T03_FRAME_COUNT_EN
    logic [7:0] r_frame_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (w_pix_tick && w_h_wrap && w_v_wrap) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

    assign Hcnt        = r_hcnt;
    assign Vcnt        = r_vcnt;
    assign pix_tick    = w_pix_tick;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: doc/t03_pixel_counter.md
Name: t03_pixel_counter

Overview:
- Timing generator that sits directly upstream of the VGA sync/display comparator stage.
- Divides the system clock down to a pixel rate and drives free-running 11-bit horizontal and vertical counters (Hcnt, Vcnt) that the comparator decodes into hsync, vsync and at_display.
- Also produces one-cycle line-start and frame-start strobes and a pixel-tick strobe for downstream framebuffer/pixel logic.

Parameters:
- CLK_DIV, 2: system clocks per pixel; legal range 1..16.
- H_TOTAL, 200: pixels per line, including sync and porches. Hcnt runs 0..H_TOTAL-1. Legal range 2..2048.
- V_TOTAL, 632: lines per frame. Vcnt runs 0..V_TOTAL-1. Legal range 2..2048.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; low freezes the divider and both counters.
- Hcnt  output  11  horizontal pixel count; registered.
- Vcnt  output  11  vertical line count; registered.
- pix_tick  output  1  combinational; high in the clk cycle whose closing edge advances Hcnt.
- line_start  output  1  registered; one-clk pulse on the first cycle Hcnt==0 after a horizontal wrap.
- frame_start  output  1  registered; one-clk pulse on the first cycle Hcnt==0 && Vcnt==0 after a frame wrap.

Behaviour:
- Reset (rst high at a rising edge):
  - div_cnt, Hcnt and Vcnt all go to 0; line_start=0; frame_start=0.
  - rst overrides en and all other activity, including mid-line and mid-frame.
  - No line_start or frame_start pulse is generated by leaving reset. The first pulses come at the first natural wrap.
- Divider:
  - div_cnt is $clog2(CLK_DIV)-wide, minimum 1 bit.
  - When en=1, div_cnt increments each clk and wraps from CLK_DIV-1 to 0.
  - pix_tick = en && (div_cnt == CLK_DIV-1). With CLK_DIV=1, pix_tick equals en.
- Counters (update only on clk edges where pix_tick=1):
  - Normal step: Hcnt <= Hcnt+1.
  - If Hcnt >= H_TOTAL-1: Hcnt <= 0, and Vcnt advances.
    - Vcnt <= Vcnt+1, except Vcnt >= V_TOTAL-1 gives Vcnt <= 0.
  - The >= comparisons make out-of-range values self-recover in one tick.
- Strobes:
  - line_start <= pix_tick && (Hcnt >= H_TOTAL-1). It is therefore high in exactly the clk cycle where the new Hcnt==0 first appears.
  - frame_start <= the same condition && (Vcnt >= V_TOTAL-1). It coincides with the line_start that begins line 0.
  - Each strobe lasts exactly one clk, independent of CLK_DIV.
- en low:
  - div_cnt, Hcnt and Vcnt hold their values.
  - pix_tick=0, so line_start and frame_start are 0 from the next edge.
  - When en returns high, counting resumes from the held div_cnt phase. No phase reset.
- Width:
  - All count arithmetic is 11-bit unsigned.
  - H_TOTAL or V_TOTAL = 2048 wraps naturally at 2047.
- Outputs are glitch-free registers, except pix_tick.
- Latency: 0 clk from counter state to Hcnt/Vcnt, since the counters are the outputs.

Optional Feature:
- Macro: T03_FRAME_COUNT_EN.
- Defined:
  - Adds output port frame_cnt [7:0], reset to 0.
  - Increments on every edge that sets frame_start; wraps 255 -> 0.
  - Holds while en=0.
- Undefined:
  - Port and register are absent.
  - All other behaviour is identical.

Test Plan:
- Reset: drive rst=1 for 3 clks with en=1, then release.
  - During reset: Hcnt=0, Vcnt=0, line_start=0, frame_start=0.
  - First clk after release: pix_tick=0 (CLK_DIV=2).
- Line wrap (defaults, en=1 from reset release):
  - Hcnt increments every 2 clks; Hcnt=199 after 398 clks.
  - At clk 400: Hcnt=0, Vcnt=1, line_start=1 for exactly 1 clk, frame_start=0.
- Frame wrap (defaults):
  - After 200*632*2 = 252800 clks: Hcnt=0, Vcnt=0, line_start=1 and frame_start=1 for 1 clk.
  - frame_cnt=1 when T03_FRAME_COUNT_EN is defined.
- Pause at Hcnt=57, Vcnt=3: drop en for 10 clks.
  - Hcnt/Vcnt stay 57/3; pix_tick=0 throughout.
  - On re-enable, Hcnt=58 appears after the remaining divider phase.
- Mid-frame reset at Vcnt=300, Hcnt=120: assert rst for 1 clk.
  - Next cycle: Hcnt=0, Vcnt=0, frame_start=0, line_start=0, div_cnt restarted.
- CLK_DIV=1, H_TOTAL=4, V_TOTAL=3:
  - Hcnt sequence is 0,1,2,3,0,... on every clk.
  - frame_start fires every 12 clks.
  - frame_cnt wraps 255 -> 0 after 256*12 clks when the macro is defined.
